// File: rtl/cpu_top.sv
// Multi-cycle (5-state) 32-bit CPU core with external synchronous instruction
// and data memories; one instruction retires every five clocks.

module cpu_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o
);
    // Flop-based so that every register can be cleared by reset.
    logic [31:0] rw_reg [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rw_reg[i] <= '0;
            end
        end else if (we_i) begin
            rw_reg[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = rw_reg[raddr_a_i];
    assign rdata_b_o = rw_reg[raddr_b_i];
endmodule

module cpu_top (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    output logic [9:0]  pc,
    output logic        IM_enable,
    output logic        IM_read,
    output logic        IM_write,
    output logic        DM_enable,
    output logic        DM_read,
    output logic        DM_write,
    output logic [11:0] DM_address,
    output logic [31:0] DM_in,
    input  logic [31:0] DM_out,
    output logic        alu_overflow
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    localparam logic [5:0] OP_ALU1 = 6'b100000;
    localparam logic [5:0] OP_MOVI = 6'b100010;
    localparam logic [5:0] OP_ADDI = 6'b101000;
    localparam logic [5:0] OP_ORI  = 6'b101100;
    localparam logic [5:0] OP_XORI = 6'b101011;
    localparam logic [5:0] OP_LWI  = 6'b000010;
    localparam logic [5:0] OP_SWI  = 6'b001010;

    localparam logic [4:0] SUB_ADD   = 5'b00000;
    localparam logic [4:0] SUB_SUB   = 5'b00001;
    localparam logic [4:0] SUB_AND   = 5'b00010;
    localparam logic [4:0] SUB_XOR   = 5'b00011;
    localparam logic [4:0] SUB_OR    = 5'b00100;
    localparam logic [4:0] SUB_SLLI  = 5'b01000;
    localparam logic [4:0] SUB_SRLI  = 5'b01001;
    localparam logic [4:0] SUB_ROTRI = 5'b01011;

    state_t      state_q, state_d;
    logic [9:0]  pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;

    logic [5:0]  opcode;
    logic [4:0]  rt, ra, rb, subop;
    logic [31:0] rdata_a, rdata_b;
    logic [31:0] imm15_sx, imm15_zx;
    logic        is_lwi, is_swi;
    logic        alu_valid, alu_ovf;
    logic [31:0] alu_res;
    logic        rf_we;
    logic [31:0] rf_wdata;

    assign opcode   = ir_q[30:25];
    assign rt       = ir_q[24:20];
    assign ra       = ir_q[19:15];
    assign rb       = ir_q[14:10];
    assign subop    = ir_q[4:0];
    assign imm15_sx = {{17{ir_q[14]}}, ir_q[14:0]};
    assign imm15_zx = {17'd0, ir_q[14:0]};
    assign is_lwi   = !ir_q[31] && (opcode == OP_LWI);
    assign is_swi   = !ir_q[31] && (opcode == OP_SWI);

    // Port B doubles as the store-data read for SWI.
    cpu_regfile REGFILE (
        .clk       (clk),
        .rst       (rst),
        .we_i      (rf_we),
        .waddr_i   (rt),
        .wdata_i   (rf_wdata),
        .raddr_a_i (ra),
        .raddr_b_i (is_swi ? rt : rb),
        .rdata_a_o (rdata_a),
        .rdata_b_o (rdata_b)
    );

    always_comb begin
        alu_valid = 1'b0;
        alu_ovf   = 1'b0;
        alu_res   = '0;
        if (!ir_q[31]) begin
            case (opcode)
                OP_MOVI: begin
                    alu_valid = 1'b1;
                    alu_res   = {{12{ir_q[19]}}, ir_q[19:0]};
                end
                OP_ADDI: begin
                    alu_valid = 1'b1;
                    alu_res   = rdata_a + imm15_sx;
                    alu_ovf   = (rdata_a[31] == imm15_sx[31]) && (alu_res[31] != rdata_a[31]);
                end
                OP_ORI: begin
                    alu_valid = 1'b1;
                    alu_res   = rdata_a | imm15_zx;
                end
                OP_XORI: begin
                    alu_valid = 1'b1;
                    alu_res   = rdata_a ^ imm15_zx;
                end
                OP_ALU1: begin
                    alu_valid = 1'b1;
                    case (subop)
                        SUB_ADD: begin
                            alu_res = rdata_a + rdata_b;
                            alu_ovf = (rdata_a[31] == rdata_b[31]) && (alu_res[31] != rdata_a[31]);
                        end
                        SUB_SUB: begin
                            alu_res = rdata_a - rdata_b;
                            alu_ovf = (rdata_a[31] != rdata_b[31]) && (alu_res[31] != rdata_a[31]);
                        end
                        SUB_AND:  alu_res = rdata_a & rdata_b;
                        SUB_XOR:  alu_res = rdata_a ^ rdata_b;
                        SUB_OR:   alu_res = rdata_a | rdata_b;
                        SUB_SLLI: alu_res = rdata_a << rb;
                        SUB_SRLI: alu_res = rdata_a >> rb;
                        // A zero rotate would otherwise shift left by the full width.
                        SUB_ROTRI: alu_res = (rb == 5'd0) ? rdata_a :
                                   ((rdata_a >> rb) | (rdata_a << (6'd32 - {1'b0, rb})));
                        default:  alu_valid = 1'b0;
                    endcase
                end
                default: alu_valid = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_EXEC;
                ir_d    = instruction;
            end
            S_EXEC: begin
                state_d  = S_MEM;
                result_d = alu_res;
                if (alu_valid) begin
                    ovf_d = alu_ovf;
                end
            end
            S_MEM: state_d = S_WB;
            S_WB: begin
                state_d = S_FETCH;
                pc_d    = pc_q + 10'd4;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    // Writeback only for legal ALU-class ops and LWI; stores never reach here.
    assign rf_we    = !rst && (state_q == S_WB) && (alu_valid || is_lwi);
    assign rf_wdata = is_lwi ? DM_out : result_q;

    assign pc           = pc_q;
    assign alu_overflow = ovf_q;
    assign IM_enable    = !rst && (state_q == S_FETCH);
    assign IM_read      = !rst && (state_q == S_FETCH);
    assign IM_write     = 1'b0;
    assign DM_enable    = !rst && (state_q == S_MEM) && (is_lwi || is_swi);
    assign DM_read      = !rst && (state_q == S_MEM) && is_lwi;
    assign DM_write     = !rst && (state_q == S_MEM) && is_swi;
    assign DM_address   = rdata_a[11:0] + {ir_q[9:0], 2'b00};
    assign DM_in        = rdata_b;
endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top: directed programs, retire/store scoreboard, reset and abort checks.

module tb_cpu_top;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction;
    logic [9:0]  pc;
    logic        IM_enable, IM_read, IM_write;
    logic        DM_enable, DM_read, DM_write;
    logic [11:0] DM_address;
    logic [31:0] DM_in, DM_out;
    logic        alu_overflow;

    always #5 clk = ~clk;

    cpu_top dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc(pc),
        .IM_enable(IM_enable), .IM_read(IM_read), .IM_write(IM_write),
        .DM_enable(DM_enable), .DM_read(DM_read), .DM_write(DM_write),
        .DM_address(DM_address), .DM_in(DM_in), .DM_out(DM_out),
        .alu_overflow(alu_overflow)
    );

    // Memory models; on a reset edge with ld_img set, IM takes the staged image instead of zeros.
    logic [31:0] im [1024];
    logic [31:0] dm [1024];
    logic [31:0] stage [1024];
    logic        ld_img = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) im[i] <= ld_img ? stage[i] : 32'd0;
            instruction <= 32'd0;
        end else if (IM_enable && IM_read) begin
            instruction <= im[{2'b00, pc[9:2]}];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) dm[i] <= 32'd0;
            DM_out <= 32'd0;
        end else if (DM_enable) begin
            if (DM_write) dm[DM_address[11:2]] <= DM_in;
            if (DM_read)  DM_out <= dm[DM_address[11:2]];
        end
    end

    typedef struct { logic chk; logic [4:0] rd; logic [31:0] val; logic ovf; logic [9:0] pc; } ret_t;
    typedef struct { logic [11:0] addr; logic [31:0] data; } st_t;

    ret_t ret_q[$];
    ret_t pend_q[$];
    st_t  st_q[$];
    int   n_instr;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] f_movi(input logic [4:0] rt, input logic [19:0] imm);
        f_movi = {1'b0, 6'b100010, rt, imm};
    endfunction

    function automatic logic [31:0] f_i15(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] ra, input logic [14:0] imm);
        f_i15 = {1'b0, op, rt, ra, imm};
    endfunction

    function automatic logic [31:0] f_alu(input logic [4:0] rt, input logic [4:0] ra,
                                          input logic [4:0] rb, input logic [4:0] sub);
        f_alu = {1'b0, 6'b100000, rt, ra, rb, 5'd0, sub};
    endfunction

    task automatic new_prog();
        for (int i = 0; i < 1024; i++) stage[i] = 32'd0;
        n_instr = 0;
        pend_q.delete();
    endtask

    task automatic emit(input logic [31:0] w, input logic expect_retire, input logic c,
                        input logic [4:0] rd, input logic [31:0] val, input logic ovf);
        ret_t e;
        stage[n_instr] = w;
        n_instr++;
        e.chk = c; e.rd = rd; e.val = val; e.ovf = ovf; e.pc = 10'(n_instr * 4);
        if (expect_retire) pend_q.push_back(e);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2;
        rst = 1'b0;
        ld_img = 1'b0;
        foreach (pend_q[i]) ret_q.push_back(pend_q[i]);
        pend_q.delete();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_pc"}, {22'd0, pc}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, alu_overflow}, 32'd0);
        chk({tag, "_strobes"}, {26'd0, IM_enable, IM_read, IM_write, DM_enable, DM_read, DM_write}, 32'd0);
        for (int i = 0; i < 32; i++) chk($sformatf("%s_r%0d", tag, i), dut.REGFILE.rw_reg[i], 32'd0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((ret_q.size() != 0 || st_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", 32'(ret_q.size() + st_q.size()), 32'd0);
        ret_q.delete();
        st_q.delete();
    endtask

    // Monitor: a pc change marks a retire; a DM write strobe marks a store.
    initial begin
        logic [9:0] last_pc = '0;
        int         cnt = 0;
        bit         first = 1'b1;
        ret_t       e;
        st_t        s;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_pc = pc;
                cnt = 0;
                first = 1'b1;
            end else begin
                cnt++;
                if (DM_enable && DM_write) begin
                    if (st_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_store actual=%h@%h required=none", DM_in, DM_address);
                    end else begin
                        s = st_q.pop_front();
                        chk("store_addr", {20'd0, DM_address}, {20'd0, s.addr});
                        chk("store_data", DM_in, s.data);
                    end
                end
                if (pc != last_pc) begin
                    if (ret_q.size() != 0) begin
                        e = ret_q.pop_front();
                        $display("retire pc=%h ovf=%b", pc, alu_overflow);
                        chk("retire_pc", {22'd0, pc}, {22'd0, e.pc});
                        if (e.chk) chk($sformatf("reg_r%0d", e.rd), dut.REGFILE.rw_reg[e.rd], e.val);
                        chk("overflow", {31'd0, alu_overflow}, {31'd0, e.ovf});
                        chk("cycles", 32'(cnt), first ? 32'd6 : 32'd5);
                        chk("im_write", {31'd0, IM_write}, 32'd0);
                    end
                    last_pc = pc;
                    cnt = 0;
                    first = 1'b0;
                end
            end
        end
    end

    initial begin
        st_t s;
        int  n;
        new_prog();
        emit(f_movi(5'd0, 20'd4),                        1, 1, 5'd0,  32'd4,        0);
        emit(f_i15(6'b101000, 5'd0, 5'd0, 15'd13),       1, 1, 5'd0,  32'd17,       0);
        emit(f_i15(6'b101100, 5'd1, 5'd0, 15'd3),        1, 1, 5'd1,  32'd19,       0);
        emit(f_i15(6'b101011, 5'd1, 5'd1, 15'd7),        1, 1, 5'd1,  32'd20,       0);
        emit(f_movi(5'd1, 20'hFFFFF),                    1, 1, 5'd1,  32'hFFFFFFFF, 0);
        emit(f_alu(5'd1, 5'd1, 5'd1, 5'b01001),          1, 1, 5'd1,  32'h7FFFFFFF, 0);
        emit(f_movi(5'd2, 20'd1),                        1, 1, 5'd2,  32'd1,        0);
        emit(f_alu(5'd3, 5'd1, 5'd2, 5'b00000),          1, 1, 5'd3,  32'h80000000, 1);
        emit(f_alu(5'd6, 5'd3, 5'd1, 5'b00010),          1, 1, 5'd6,  32'd0,        0);
        emit(f_movi(5'd2, 20'h11),                       1, 1, 5'd2,  32'h11,       0);
        emit(f_alu(5'd2, 5'd2, 5'd4, 5'b01011),          1, 1, 5'd2,  32'h10000001, 0);
        emit(f_movi(5'd7, 20'd2),                        1, 1, 5'd7,  32'd2,        0);
        emit(f_alu(5'd7, 5'd7, 5'd3, 5'b01000),          1, 1, 5'd7,  32'd16,       0);
        emit(f_movi(5'd8, 20'd8),                        1, 1, 5'd8,  32'd8,        0);
        emit(f_alu(5'd8, 5'd8, 5'd2, 5'b01001),          1, 1, 5'd8,  32'd2,        0);
        emit(f_i15(6'b001010, 5'd0, 5'd5, 15'd1),        1, 0, 5'd0,  32'd0,        0);
        emit(f_i15(6'b000010, 5'd4, 5'd5, 15'd1),        1, 1, 5'd4,  32'd17,       0);
        emit(f_alu(5'd9, 5'd3, 5'd2, 5'b00001),          1, 1, 5'd9,  32'h6FFFFFFF, 1);
        emit(32'h80000000 | f_movi(5'd10, 20'd5),        1, 1, 5'd10, 32'd0,        1);
        emit(f_i15(6'b000010, 5'd11, 5'd5, 15'd1),       1, 1, 5'd11, 32'd17,       1);
        emit(f_alu(5'd13, 5'd0, 5'd0, 5'b00101),         1, 1, 5'd13, 32'd0,        1);
        emit(f_alu(5'd12, 5'd0, 5'd0, 5'b00001),         1, 1, 5'd12, 32'd0,        0);
        emit(f_alu(5'd14, 5'd3, 5'd0, 5'b01011),         1, 1, 5'd14, 32'h80000000, 0);
        emit(f_i15(6'b101000, 5'd15, 5'd5, 15'h7FFF),    1, 1, 5'd15, 32'hFFFFFFFF, 0);
        emit(f_alu(5'd16, 5'd3, 5'd3, 5'b00000),         1, 1, 5'd16, 32'd0,        1);
        emit(f_i15(6'b101100, 5'd17, 5'd5, 15'h7FFF),    1, 1, 5'd17, 32'h00007FFF, 0);
        emit(f_i15(6'b101011, 5'd18, 5'd1, 15'h7FFF),    1, 1, 5'd18, 32'h7FFF8000, 0);
        emit(f_alu(5'd19, 5'd2, 5'd7, 5'b00100),         1, 1, 5'd19, 32'h10000011, 0);
        emit(f_i15(6'b101000, 5'd21, 5'd1, 15'd1),       1, 1, 5'd21, 32'h80000000, 1);
        emit(f_alu(5'd22, 5'd2, 5'd31, 5'b01000),        1, 1, 5'd22, 32'h80000000, 0);
        s.addr = 12'h004; s.data = 32'd17;
        st_q.push_back(s);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("por");
        ld_img = 1'b1;
        release_rst();
        drain(400);

        // Abort: reset lands in the EXEC cycle of an ADD.
        @(posedge clk);
        #2 rst = 1'b1;
        new_prog();
        emit(f_movi(5'd1, 20'd5),               1, 1, 5'd1, 32'd5, 0);
        emit(f_movi(5'd2, 20'd6),               1, 1, 5'd2, 32'd6, 0);
        emit(f_alu(5'd3, 5'd1, 5'd2, 5'b00000), 0, 1, 5'd3, 32'd11, 0);
        @(posedge clk);
        @(negedge clk);
        ld_img = 1'b1;
        release_rst();
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (pc != 10'd8 && n < 100);
        chk("abort_reach_pc8", {22'd0, pc}, 32'd8);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_checks("abort");
        chk("abort_pending", 32'(ret_q.size()), 32'd0);
        ret_q.delete();

        new_prog();
        emit(f_movi(5'd0, 20'd4), 1, 1, 5'd0, 32'd4, 0);
        ld_img = 1'b1;
        release_rst();
        drain(100);
        chk("restart_r3", dut.REGFILE.rw_reg[3], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_top.md
CPU_TOP -- requirements
Module: cpu_top

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL have instruction in 32: instruction word returned by instruction memory.
REQ-003 SHALL have pc out 10: byte address of current instruction; memory word index = pc/4.
REQ-004 SHALL have IM_enable, IM_read, IM_write out 1 each: instruction-memory strobes; IM_write tied 0.
REQ-005 SHALL have DM_enable, DM_read, DM_write out 1 each: data-memory strobes.
REQ-006 SHALL have DM_address out 12: data byte address; memory word index = DM_address/4.
REQ-007 SHALL have DM_in out 32: store data to memory; DM_out in 32: load data from memory.
REQ-008 SHALL have alu_overflow out 1: signed-overflow flag of last ALU-class instruction.
REQ-009 SHALL contain a 32x32 register file instance REGFILE with array rw_reg, R0 ordinary (writable).

Function
REQ-010 SHALL execute each instruction in exactly 5 cycles via FSM FETCH->DECODE->EXEC->MEM->WB->FETCH, no pipelining.
REQ-011 FETCH: IM_enable=1, IM_read=1; memory is synchronous, instruction valid during DECODE.
REQ-012 DECODE: IR latched from instruction at end of cycle; IM strobes 0.
REQ-013 EXEC: operands read from rw_reg, result latched into ALU result register at end of cycle.
REQ-014 MEM: LWI asserts DM_enable=1, DM_read=1; SWI asserts DM_enable=1, DM_write=1, DM_in=rt value; DM_address=ra+(sign-extended imm15<<2), low 12 bits; other states drive DM strobes 0.
REQ-015 WB: register write of result (LWI writes DM_out); pc<=pc+4 mod 1024 at end of WB.
REQ-016 Encoding: bit31=0; opcode [30:25]; rt [24:20]; ra [19:15]; rb/imm5 [14:10]; sub-op [4:0].
REQ-017 MOVI opcode 100010: rt = sign-extended imm20 [19:0].
REQ-018 ADDI 101000: rt = ra + sign-extended imm15 [14:0]; ORI 101100: rt = ra | zero-extended imm15; XORI 101011: rt = ra ^ zero-extended imm15.
REQ-019 ALU_1 opcode 100000 by sub-op: ADD 00000 ra+rb; SUB 00001 ra-rb; AND 00010; XOR 00011; OR 00100; SLLI 01000 ra<<imm5; SRLI 01001 ra>>imm5 logical; ROTRI 01011 ra rotated right by imm5.
REQ-020 LWI opcode 000010: rt = mem word; SWI opcode 001010: mem word = rt.
REQ-021 Arithmetic 32-bit modulo 2^32; shift amount 0 returns operand unchanged.
REQ-022 alu_overflow SHALL update at end of EXEC for MOVI/ADDI/ORI/XORI/ALU_1: 1 only on signed overflow of ADD, ADDI, SUB; else 0; held during LWI/SWI and illegal ops.
REQ-023 Undefined opcode/sub-op or bit31=1 SHALL act as NOP: no register or memory write, pc still advances.
REQ-024 Register write and memory write SHALL never occur in the same instruction.

Reset
REQ-025 rst sampled high SHALL set FSM=FETCH, pc=0, IR=0, alu_overflow=0, all rw_reg=0, all strobes 0 (strobes driven 0 while rst high).
REQ-026 rst high mid-instruction SHALL abort it with no register/memory write; first FETCH follows cycle after rst low.
REQ-027 Companion im/dm models SHALL be 1024x32 and 1024x32 synchronous memories cleared on reset.

Verification
REQ-028 MOVI R0,4 after reset -> after 5 cycles rw_reg[0]=4, pc=4.
REQ-029 ADDI R0,R0,13 -> R0=17; ORI R1,R0,3 -> R1=19; XORI R1,R1,7 -> R1=20.
REQ-030 R1=0x7FFFFFFF, R2=1, ADD R3,R1,R2 -> R3=0x80000000, alu_overflow=1; next AND clears to 0.
REQ-031 R2=0x11, ROTRI R2,R2,4 -> 0x10000001; SLLI by 3 of 2 -> 16; SRLI by 2 of 8 -> 2.
REQ-032 SWI R0,[R5+1] with R5=0, R0=17 -> DM word 1=17, DM_address=4; LWI R4,[R5+1] -> R4=17.
REQ-033 Assert rst during EXEC of ADD -> no write, pc=0, registers 0, restart at FETCH.
